// File: rtl/sym_stream_arbiter_pkg.sv
// Shared types and defaults for the symbol-stream arbiter: state encodings,
// trap/idle codes and default parameter values.
package sym_stream_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRIVE = 2'd1,
    ST_FLUSH = 2'd2
  } arb_state_e;

  localparam logic [2:0] TRAP_STATE_DEF = 3'd4;
  localparam logic [1:0] IDLE_SYM_DEF   = 2'd1;
  localparam int         N_REQ_DEF      = 4;
  localparam int         MAX_BURST_DEF  = 8;
  localparam int         CLR_CYCLES_DEF = 2;

  // Index width for N requesters; never below one bit.
  function automatic int idx_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/sym_stream_arbiter_if.sv
// Bundle between the requester front-ends, the shared symbol FSM and the arbiter.
interface sym_stream_arbiter_if #(
  parameter int N_REQ = 4
);
  // Handshake: req[i] is valid with req_sym/req_last of lane i; the arbiter is
  // ready for lane i only while gnt[i] is high, and a symbol transfers in a
  // cycle where sym_ack is high. Requesters hold req, req_sym and req_last
  // stable until the transfer; a request is never dropped by the arbiter.
  logic [N_REQ-1:0]   req;
  logic [2*N_REQ-1:0] req_sym;
  logic [N_REQ-1:0]   req_last;
  logic [2:0]         fsm_state;

  logic [N_REQ-1:0]   gnt;
  logic               sym_ack;
  logic [1:0]         fsm_in;
  logic               fsm_clr;
  logic               abort;
  logic [2:0]         abort_id;
  logic               busy;
  logic [3:0]         burst_cnt;
  logic [1:0]         dbg_state;
  logic [2:0]         dbg_rr_ptr;

  modport master (
    output req, req_sym, req_last, fsm_state,
    input  gnt, sym_ack, fsm_in, fsm_clr, abort, abort_id, busy, burst_cnt,
    input  dbg_state, dbg_rr_ptr
  );

  modport slave (
    input  req, req_sym, req_last, fsm_state,
    output gnt, sym_ack, fsm_in, fsm_clr, abort, abort_id, busy, burst_cnt,
    output dbg_state, dbg_rr_ptr
  );

endinterface

// File: rtl/sym_stream_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request at or after ptr_i,
// wrapping to index 0.
module sym_stream_arbiter_rr_pick
  import sym_stream_arbiter_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int IDX_W = idx_width(N_REQ)
) (
  input  logic [N_REQ-1:0] req_i,
  input  logic [IDX_W-1:0] ptr_i,
  output logic [N_REQ-1:0] pick_o,
  output logic [IDX_W-1:0] idx_o,
  output logic             any_o
);

  logic found;

  always_comb begin
    pick_o = '0;
    idx_o  = '0;
    found  = 1'b0;
    // Upper segment [ptr, N-1] first, then wrap into [0, ptr-1].
    for (int j = 0; j < N_REQ; j++) begin
      if (!found && req_i[j] && (j >= int'(ptr_i))) begin
        found     = 1'b1;
        pick_o[j] = 1'b1;
        idx_o     = IDX_W'(j);
      end
    end
    for (int j = 0; j < N_REQ; j++) begin
      if (!found && req_i[j]) begin
        found     = 1'b1;
        pick_o[j] = 1'b1;
        idx_o     = IDX_W'(j);
      end
    end
    any_o = found;
  end

endmodule

// File: rtl/sym_stream_arbiter.sv
// Round-robin arbiter that lends one shared symbol FSM to N_REQ requesters,
// streams the owner's symbols into it and clears it after a trap.
module sym_stream_arbiter
  import sym_stream_arbiter_pkg::*;
#(
  parameter int         N_REQ      = N_REQ_DEF,
  parameter int         MAX_BURST  = MAX_BURST_DEF,
  parameter logic [2:0] TRAP_STATE = TRAP_STATE_DEF,
  parameter logic [1:0] IDLE_SYM   = IDLE_SYM_DEF,
  parameter int         CLR_CYCLES = CLR_CYCLES_DEF
) (
  input  logic                 clk,
  input  logic                 clr,
  sym_stream_arbiter_if.slave  bus
);

  localparam int IDX_W = idx_width(N_REQ);

  arb_state_e       state_q, state_d;
  logic [N_REQ-1:0] gnt_q, gnt_d;
  logic [1:0]       fsm_in_q, fsm_in_d;
  logic             fsm_clr_q, fsm_clr_d;
  logic             abort_q, abort_d;
  logic [2:0]       abort_id_q, abort_id_d;
  logic             busy_q, busy_d;
  logic [3:0]       burst_cnt_q, burst_cnt_d;
  logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [IDX_W-1:0] owner_q, owner_d;
  logic [1:0]       flush_cnt_q, flush_cnt_d;

  logic             ack;
  logic             trap;
  logic [N_REQ-1:0] pick_onehot;
  logic [IDX_W-1:0] pick_idx;
  logic             pick_any;
  logic [1:0]       owner_sym;
  logic             owner_last;
  logic [IDX_W-1:0] owner_nxt;

  sym_stream_arbiter_rr_pick #(
    .N_REQ (N_REQ),
    .IDX_W (IDX_W)
  ) u_rr_pick (
    .req_i  (bus.req),
    .ptr_i  (rr_ptr_q),
    .pick_o (pick_onehot),
    .idx_o  (pick_idx),
    .any_o  (pick_any)
  );

  assign trap       = (bus.fsm_state == TRAP_STATE);
  assign owner_sym  = bus.req_sym[{owner_q, 1'b0} +: 2];
  assign owner_last = bus.req_last[owner_q];
  assign owner_nxt  = (owner_q == IDX_W'(N_REQ - 1)) ? '0 : owner_q + IDX_W'(1);

  always_comb begin
    state_d     = state_q;
    gnt_d       = gnt_q;
    fsm_in_d    = IDLE_SYM;
    fsm_clr_d   = 1'b0;
    abort_d     = 1'b0;
    abort_id_d  = abort_id_q;
    burst_cnt_d = burst_cnt_q;
    rr_ptr_d    = rr_ptr_q;
    owner_d     = owner_q;
    flush_cnt_d = flush_cnt_q;
    ack         = 1'b0;

    case (state_q)
      ST_IDLE: begin
        // A trap seen while nobody owns the FSM is cleared without an abort.
        if (trap) begin
          state_d     = ST_FLUSH;
          fsm_clr_d   = 1'b1;
          flush_cnt_d = '0;
        end else if (pick_any) begin
          gnt_d       = pick_onehot;
          owner_d     = pick_idx;
          burst_cnt_d = '0;
          state_d     = ST_DRIVE;
        end
      end

      ST_DRIVE: begin
        if (trap) begin
          abort_d     = 1'b1;
          abort_id_d  = 3'(owner_q);
          gnt_d       = '0;
          rr_ptr_d    = owner_nxt;
          state_d     = ST_FLUSH;
          fsm_clr_d   = 1'b1;
          flush_cnt_d = '0;
        end else if (bus.req[owner_q]) begin
          ack         = 1'b1;
          fsm_in_d    = owner_sym;
          burst_cnt_d = burst_cnt_q + 4'd1;
          if (owner_last || (burst_cnt_q == 4'(MAX_BURST - 1))) begin
            gnt_d    = '0;
            rr_ptr_d = owner_nxt;
            state_d  = ST_IDLE;
          end
        end
      end

      ST_FLUSH: begin
        if (flush_cnt_q == 2'(CLR_CYCLES - 1)) begin
          state_d = ST_IDLE;
        end else begin
          fsm_clr_d   = 1'b1;
          flush_cnt_d = flush_cnt_q + 2'd1;
        end
      end

      default: begin
        state_d     = ST_IDLE;
        gnt_d       = '0;
        abort_id_d  = '0;
        burst_cnt_d = '0;
        rr_ptr_d    = '0;
        owner_d     = '0;
        flush_cnt_d = '0;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_q     <= ST_IDLE;
      gnt_q       <= '0;
      fsm_in_q    <= IDLE_SYM;
      fsm_clr_q   <= 1'b0;
      abort_q     <= 1'b0;
      abort_id_q  <= '0;
      busy_q      <= 1'b0;
      burst_cnt_q <= '0;
      rr_ptr_q    <= '0;
      owner_q     <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      gnt_q       <= gnt_d;
      fsm_in_q    <= fsm_in_d;
      fsm_clr_q   <= fsm_clr_d;
      abort_q     <= abort_d;
      abort_id_q  <= abort_id_d;
      busy_q      <= busy_d;
      burst_cnt_q <= burst_cnt_d;
      rr_ptr_q    <= rr_ptr_d;
      owner_q     <= owner_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  // The system-level FSM clear is fsm_clr ORed with clr outside this block.
  assign bus.gnt        = gnt_q;
  assign bus.sym_ack    = ack;
  assign bus.fsm_in     = fsm_in_q;
  assign bus.fsm_clr    = fsm_clr_q;
  assign bus.abort      = abort_q;
  assign bus.abort_id   = abort_id_q;
  assign bus.busy       = busy_q;
  assign bus.burst_cnt  = burst_cnt_q;
  assign bus.dbg_state  = state_q;
  assign bus.dbg_rr_ptr = 3'(rr_ptr_q);

endmodule

// File: tb/tb_sym_stream_arbiter.sv
// Bench for sym_stream_arbiter: reset checks, vector table, corner-case
// sequences and a randomized run against a cycle model.
module tb_sym_stream_arbiter;

  localparam int         N    = 4;
  localparam int         MB   = 8;
  localparam int         CLRC = 2;
  localparam logic [2:0] TRAP = 3'd4;
  localparam logic [1:0] ISYM = 2'd1;

  logic clk = 1'b0;
  logic clr;

  sym_stream_arbiter_if #(.N_REQ(N)) bus();

  sym_stream_arbiter #(
    .N_REQ      (N),
    .MAX_BURST  (MB),
    .TRAP_STATE (TRAP),
    .IDLE_SYM   (ISYM),
    .CLR_CYCLES (CLRC)
  ) dut (
    .clk (clk),
    .clr (clr),
    .bus (bus)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int total = 0;
  int bad   = 0;
  logic [3:0] exp_q[$];

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got=%0d expected=%0d", nm, act, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive(input logic [3:0] r, input logic [7:0] s,
                       input logic [3:0] l, input logic [2:0] f);
    bus.req       = r;
    bus.req_sym   = s;
    bus.req_last  = l;
    bus.fsm_state = f;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    clr = 1'b1;
    drive(4'h0, 8'h00, 4'h0, 3'd0);
    tick;
    tick;
    clr = 1'b0;
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [3:0] r;
    logic [1:0] s;
    logic       l;
    logic [2:0] f;
    logic       e_ack;
    logic [3:0] e_gnt;
    logic [1:0] e_fin;
    logic [3:0] e_burst;
    logic       e_clr;
    logic       e_ab;
    logic [2:0] e_abid;
    logic       e_busy;
    logic [2:0] e_ptr;
  } vec_t;

  vec_t tbl[20];

  function automatic vec_t mk(input logic [3:0] r, input logic [1:0] s, input logic l,
                              input logic [2:0] f, input logic ack, input logic [3:0] g,
                              input logic [1:0] fin, input logic [3:0] b, input logic c,
                              input logic ab, input logic [2:0] abid, input logic busy,
                              input logic [2:0] ptr);
    vec_t v;
    v.r = r; v.s = s; v.l = l; v.f = f; v.e_ack = ack; v.e_gnt = g; v.e_fin = fin;
    v.e_burst = b; v.e_clr = c; v.e_ab = ab; v.e_abid = abid; v.e_busy = busy; v.e_ptr = ptr;
    return v;
  endfunction

  // ---------------- reference model ----------------
  int         m_owner, m_flush, m_ptr, m_cnt, m_abid;
  logic [1:0] m_fin;
  logic       m_abort;

  function automatic int m_pick(input logic [3:0] r);
    for (int k = 0; k < N; k++) begin
      int i;
      i = (m_ptr + k) % N;
      if (r[i]) return i;
    end
    return -1;
  endfunction

  task automatic m_step(input logic [3:0] r, input logic [7:0] s,
                        input logic [3:0] l, input logic [2:0] f);
    logic trap;
    trap    = (f == TRAP);
    m_abort = 1'b0;
    m_fin   = ISYM;
    if (m_flush > 0) begin
      m_flush--;
    end else if (m_owner < 0) begin
      if (trap) m_flush = CLRC;
      else if (m_pick(r) >= 0) begin
        m_owner = m_pick(r);
        m_cnt   = 0;
      end
    end else if (trap) begin
      m_abort = 1'b1;
      m_abid  = m_owner;
      m_ptr   = (m_owner + 1) % N;
      m_owner = -1;
      m_flush = CLRC;
    end else if (r[m_owner]) begin
      m_fin = s[2*m_owner +: 2];
      m_cnt++;
      if (l[m_owner] || m_cnt == MB) begin
        m_ptr   = (m_owner + 1) % N;
        m_owner = -1;
      end
    end
  endtask

  // ---------------- stimulus and checks ----------------
  initial begin
    logic [7:0] s;
    logic [3:0] r, l;
    logic [2:0] f;
    logic       e_ack;

    clr = 1'b1;
    drive(4'h0, 8'h00, 4'h0, 3'd0);
    #1;
    chk("rst_gnt", int'(bus.gnt), 0);
    chk("rst_fsm_in", int'(bus.fsm_in), int'(ISYM));
    chk("rst_fsm_clr", int'(bus.fsm_clr), 0);
    chk("rst_abort", int'(bus.abort), 0);
    chk("rst_abort_id", int'(bus.abort_id), 0);
    chk("rst_busy", int'(bus.busy), 0);
    chk("rst_burst", int'(bus.burst_cnt), 0);
    chk("rst_rr_ptr", int'(bus.dbg_rr_ptr), 0);
    tick;
    tick;
    clr = 1'b0;

    // Packet 2,0,3 from req0; abort of owner 2; owner 3 drops req for 3 cycles.
    tbl[0]  = mk(4'h1, 2'd2, 1'b0, 3'd0, 1'b0, 4'h1, 2'd1, 4'd0, 1'b0, 1'b0, 3'd0, 1'b1, 3'd0);
    tbl[1]  = mk(4'h1, 2'd2, 1'b0, 3'd0, 1'b1, 4'h1, 2'd2, 4'd1, 1'b0, 1'b0, 3'd0, 1'b1, 3'd0);
    tbl[2]  = mk(4'h1, 2'd0, 1'b0, 3'd0, 1'b1, 4'h1, 2'd0, 4'd2, 1'b0, 1'b0, 3'd0, 1'b1, 3'd0);
    tbl[3]  = mk(4'h1, 2'd3, 1'b1, 3'd0, 1'b1, 4'h0, 2'd3, 4'd3, 1'b0, 1'b0, 3'd0, 1'b0, 3'd1);
    tbl[4]  = mk(4'h0, 2'd0, 1'b0, 3'd0, 1'b0, 4'h0, 2'd1, 4'd3, 1'b0, 1'b0, 3'd0, 1'b0, 3'd1);
    tbl[5]  = mk(4'h4, 2'd0, 1'b0, 3'd0, 1'b0, 4'h4, 2'd1, 4'd0, 1'b0, 1'b0, 3'd0, 1'b1, 3'd1);
    tbl[6]  = mk(4'h4, 2'd2, 1'b0, 3'd0, 1'b1, 4'h4, 2'd2, 4'd1, 1'b0, 1'b0, 3'd0, 1'b1, 3'd1);
    tbl[7]  = mk(4'h4, 2'd2, 1'b0, 3'd4, 1'b0, 4'h0, 2'd1, 4'd1, 1'b1, 1'b1, 3'd2, 1'b1, 3'd3);
    tbl[8]  = mk(4'h4, 2'd2, 1'b0, 3'd0, 1'b0, 4'h0, 2'd1, 4'd1, 1'b1, 1'b0, 3'd2, 1'b1, 3'd3);
    tbl[9]  = mk(4'h4, 2'd2, 1'b0, 3'd0, 1'b0, 4'h0, 2'd1, 4'd1, 1'b0, 1'b0, 3'd2, 1'b0, 3'd3);
    tbl[10] = mk(4'h4, 2'd2, 1'b0, 3'd0, 1'b0, 4'h4, 2'd1, 4'd0, 1'b0, 1'b0, 3'd2, 1'b1, 3'd3);
    tbl[11] = mk(4'h4, 2'd3, 1'b1, 3'd0, 1'b1, 4'h0, 2'd3, 4'd1, 1'b0, 1'b0, 3'd2, 1'b0, 3'd3);
    tbl[12] = mk(4'h0, 2'd0, 1'b0, 3'd0, 1'b0, 4'h0, 2'd1, 4'd1, 1'b0, 1'b0, 3'd2, 1'b0, 3'd3);
    tbl[13] = mk(4'h8, 2'd0, 1'b0, 3'd0, 1'b0, 4'h8, 2'd1, 4'd0, 1'b0, 1'b0, 3'd2, 1'b1, 3'd3);
    tbl[14] = mk(4'h8, 2'd2, 1'b0, 3'd0, 1'b1, 4'h8, 2'd2, 4'd1, 1'b0, 1'b0, 3'd2, 1'b1, 3'd3);
    tbl[15] = mk(4'h0, 2'd2, 1'b0, 3'd0, 1'b0, 4'h8, 2'd1, 4'd1, 1'b0, 1'b0, 3'd2, 1'b1, 3'd3);
    tbl[16] = mk(4'h0, 2'd2, 1'b0, 3'd0, 1'b0, 4'h8, 2'd1, 4'd1, 1'b0, 1'b0, 3'd2, 1'b1, 3'd3);
    tbl[17] = mk(4'h0, 2'd2, 1'b0, 3'd0, 1'b0, 4'h8, 2'd1, 4'd1, 1'b0, 1'b0, 3'd2, 1'b1, 3'd3);
    tbl[18] = mk(4'h8, 2'd0, 1'b1, 3'd0, 1'b1, 4'h0, 2'd0, 4'd2, 1'b0, 1'b0, 3'd2, 1'b0, 3'd0);
    tbl[19] = mk(4'h0, 2'd0, 1'b0, 3'd0, 1'b0, 4'h0, 2'd1, 4'd2, 1'b0, 1'b0, 3'd2, 1'b0, 3'd0);

    for (int i = 0; i < 20; i++) begin
      drive(tbl[i].r, {4{tbl[i].s}}, {4{tbl[i].l}}, tbl[i].f);
      #3;
      chk($sformatf("v%0d_ack", i), int'(bus.sym_ack), int'(tbl[i].e_ack));
      tick;
      chk($sformatf("v%0d_gnt", i), int'(bus.gnt), int'(tbl[i].e_gnt));
      chk($sformatf("v%0d_fsm_in", i), int'(bus.fsm_in), int'(tbl[i].e_fin));
      chk($sformatf("v%0d_burst", i), int'(bus.burst_cnt), int'(tbl[i].e_burst));
      chk($sformatf("v%0d_fsm_clr", i), int'(bus.fsm_clr), int'(tbl[i].e_clr));
      chk($sformatf("v%0d_abort", i), int'(bus.abort), int'(tbl[i].e_ab));
      chk($sformatf("v%0d_abort_id", i), int'(bus.abort_id), int'(tbl[i].e_abid));
      chk($sformatf("v%0d_busy", i), int'(bus.busy), int'(tbl[i].e_busy));
      chk($sformatf("v%0d_rr_ptr", i), int'(bus.dbg_rr_ptr), int'(tbl[i].e_ptr));
    end

    // All four requesting single-symbol packets: grant, release, idle, next.
    do_reset;
    for (int k = 0; k < 10; k++) exp_q.push_back((k % 2 == 0) ? 4'(1 << ((k / 2) % N)) : 4'h0);
    for (int k = 0; k < 10; k++) begin
      logic [3:0] e;
      drive(4'hF, 8'($urandom), 4'hF, 3'd0);
      tick;
      e = exp_q.pop_front();
      chk($sformatf("rr_gnt_%0d", k), int'(bus.gnt), int'(e));
    end

    // Burst limit: req0 never sends last, req1 waits.
    do_reset;
    drive(4'h3, 8'h00, 4'h0, 3'd0);
    tick;
    chk("burst_first_gnt", int'(bus.gnt), 1);
    for (int k = 1; k <= MB; k++) begin
      s = 8'($urandom);
      drive(4'h3, s, 4'h0, 3'd0);
      #3;
      chk($sformatf("burst_ack_%0d", k), int'(bus.sym_ack), 1);
      tick;
      chk($sformatf("burst_fsm_in_%0d", k), int'(bus.fsm_in), int'(s[1:0]));
      chk($sformatf("burst_cnt_%0d", k), int'(bus.burst_cnt), k);
    end
    chk("burst_release_gnt", int'(bus.gnt), 0);
    drive(4'h3, 8'h00, 4'h0, 3'd0);
    tick;
    chk("burst_next_gnt", int'(bus.gnt), 2);
    drive(4'h3, 8'h00, 4'h2, 3'd0);
    tick;
    chk("burst_req1_release", int'(bus.gnt), 0);
    tick;
    chk("burst_req0_regrant", int'(bus.gnt), 1);

    // Asynchronous clear in the middle of a grant to requester 2.
    do_reset;
    drive(4'h1, 8'h00, 4'h1, 3'd0);
    tick;
    tick;
    drive(4'h4, 8'h00, 4'h0, 3'd0);
    tick;
    chk("clr_pre_gnt", int'(bus.gnt), 4);
    tick;
    chk("clr_pre_burst", int'(bus.burst_cnt), 1);
    #2;
    clr = 1'b1;
    #1;
    chk("clr_async_gnt", int'(bus.gnt), 0);
    chk("clr_async_fsm_in", int'(bus.fsm_in), int'(ISYM));
    chk("clr_async_burst", int'(bus.burst_cnt), 0);
    chk("clr_async_busy", int'(bus.busy), 0);
    chk("clr_async_abort", int'(bus.abort), 0);
    tick;
    clr = 1'b0;
    drive(4'hF, 8'h00, 4'h0, 3'd0);
    tick;
    chk("clr_first_gnt", int'(bus.gnt), 1);

    // Randomized run against the model.
    do_reset;
    m_owner = -1; m_flush = 0; m_ptr = 0; m_cnt = 0; m_abid = 0;
    m_fin = ISYM; m_abort = 1'b0;
    for (int c = 0; c < 600; c++) begin
      r = 4'($urandom_range(0, 15));
      s = 8'($urandom);
      l = 4'($urandom) & 4'($urandom);
      f = ($urandom_range(0, 19) == 0) ? TRAP : 3'($urandom_range(0, 3));
      e_ack = (m_owner >= 0) && (m_flush == 0) && r[m_owner] && (f != TRAP);
      drive(r, s, l, f);
      #3;
      chk($sformatf("rnd%0d_ack", c), int'(bus.sym_ack), int'(e_ack));
      tick;
      m_step(r, s, l, f);
      chk($sformatf("rnd%0d_gnt", c), int'(bus.gnt), (m_owner >= 0) ? (1 << m_owner) : 0);
      chk($sformatf("rnd%0d_fsm_in", c), int'(bus.fsm_in), int'(m_fin));
      chk($sformatf("rnd%0d_burst", c), int'(bus.burst_cnt), m_cnt);
      chk($sformatf("rnd%0d_fsm_clr", c), int'(bus.fsm_clr), (m_flush > 0) ? 1 : 0);
      chk($sformatf("rnd%0d_abort", c), int'(bus.abort), int'(m_abort));
      chk($sformatf("rnd%0d_abort_id", c), int'(bus.abort_id), m_abid);
      chk($sformatf("rnd%0d_busy", c), int'(bus.busy), (m_owner >= 0 || m_flush > 0) ? 1 : 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
